// File: rtl/demux_1_a_n_reg_pkg.sv
// Shared types and constants for the registered 1-to-N write demultiplexer.
package demux_pkg;

  // Per-slot occupancy state.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Slot behaviour selection.
  localparam int MODE_PULSE = 0;
  localparam int MODE_HOLD  = 1;

endpackage

// File: rtl/demux_1_a_n_reg_if.sv
// Bus bundle between the UART control logic (master) and the demux (slave).
//
// Handshake: a write is offered for one cycle with en_i=1 and a data word.
// Slot k presents data_o[k] with valid_o[k]=1 until the consumer raises
// ack_i[k] for one cycle. In HOLD mode the slot drops valid on the edge that
// samples ack_i[k], unless a new write to k lands on the same edge, in which
// case valid stays high with the new word. ack_i while valid is low is ignored.
interface demux_1_a_n_reg_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                     en_i;
  logic [SEL_W-1:0]         sel_i;
  logic [DATA_W-1:0]        data_i;
  logic [NUM_CH-1:0]        ack_i;
  logic [NUM_CH*DATA_W-1:0] data_o;
  logic [NUM_CH-1:0]        valid_o;
  logic [NUM_CH-1:0]        ovr_o;
  logic                     sel_err_o;
  logic [CNT_W-1:0]         ovr_cnt_o;
  // Debug view of every slot FSM: bit k is 1 when slot k is FULL.
  logic [NUM_CH-1:0]        slot_state_o;

  modport master (
    output en_i, sel_i, data_i, ack_i,
    input  data_o, valid_o, ovr_o, sel_err_o, ovr_cnt_o, slot_state_o
  );

  modport slave (
    input  en_i, sel_i, data_i, ack_i,
    output data_o, valid_o, ovr_o, sel_err_o, ovr_cnt_o, slot_state_o
  );
endinterface

// File: rtl/demux_1_a_n_reg_chan_slot.sv
// One output slot: holds a word and its valid flag, flags overruns.
module demux_chan_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MODE   = MODE_HOLD
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ack_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              ovr_o,
  output slot_state_t       state_o
);

  slot_state_t       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovr_q, ovr_d;

  // State, data and overrun flops; async clear of everything.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic. In PULSE mode FULL lasts exactly one cycle per write.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovr_d   = 1'b0;
    if (MODE == MODE_PULSE) begin
      state_d = wr_i ? SLOT_FULL : SLOT_EMPTY;
      if (wr_i) data_d = data_i;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (wr_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
          end
        end
        SLOT_FULL: begin
          if (wr_i && ack_i) begin
            data_d = data_i;
          end else if (wr_i) begin
            // Consumer has not taken the old word: keep it, drop the new one.
            ovr_d = 1'b1;
          end else if (ack_i) begin
            state_d = SLOT_EMPTY;
          end
        end
        default: state_d = SLOT_EMPTY;
      endcase
    end
  end

  // Valid is the FULL bit of the state flop itself.
  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;
  assign ovr_o   = ovr_q;
  assign state_o = state_q;

endmodule

// File: rtl/demux_1_a_n_reg.sv
// Registered 1-to-N write demultiplexer: select decode, range check,
// NUM_CH output slots and a saturating overrun counter.
module demux_1_a_n_reg
  import demux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = MODE_HOLD,
  parameter int CNT_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  demux_1_a_n_reg_if.slave   bus
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(NUM_CH);

  logic                     in_range;
  logic [NUM_CH-1:0]        wr;
  logic [NUM_CH-1:0]        slot_valid;
  logic [NUM_CH-1:0]        slot_ovr;
  logic [NUM_CH-1:0]        slot_full;
  logic [DATA_W-1:0]        slot_data  [NUM_CH];
  slot_state_t              slot_state [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] data_flat;
  logic                     sel_err_q;
  logic [CNT_W-1:0]         ovr_cnt_q;

  // Only non-power-of-two channel counts can produce an out-of-range select.
  assign in_range = ({1'b0, bus.sel_i} < CH_LIMIT);

  // One-hot write decode; at most one slot is written per cycle.
  always_comb begin
    wr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr[k] = bus.en_i && in_range && (bus.sel_i == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_chan_slot #(
      .DATA_W (DATA_W),
      .MODE   (MODE)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .wr_i    (wr[g]),
      .data_i  (bus.data_i),
      .ack_i   (bus.ack_i[g]),
      .data_o  (slot_data[g]),
      .valid_o (slot_valid[g]),
      .ovr_o   (slot_ovr[g]),
      .state_o (slot_state[g])
    );
  end

  // Flatten slot words and state bits onto the bus.
  always_comb begin
    data_flat = '0;
    slot_full = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      data_flat[k*DATA_W +: DATA_W] = slot_data[k];
      slot_full[k]                  = (slot_state[k] == SLOT_FULL);
    end
  end

  // Select-error pulse: high for the cycle after an out-of-range write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sel_err_q <= 1'b0;
    else          sel_err_q <= bus.en_i && !in_range;
  end

  // Saturating count of overrun pulses; it counts the registered slot
  // pulses, so the total lands one cycle after the ovr_o pulse is seen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovr_cnt_q <= '0;
    end else if ((|slot_ovr) && (ovr_cnt_q != {CNT_W{1'b1}})) begin
      ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign bus.data_o       = data_flat;
  assign bus.valid_o      = slot_valid;
  assign bus.ovr_o        = slot_ovr;
  assign bus.sel_err_o    = sel_err_q;
  assign bus.ovr_cnt_o    = ovr_cnt_q;
  assign bus.slot_state_o = slot_full;

endmodule

// File: doc/demux_1_a_n_reg.md
# demux_1_a_n_reg

Parametrised, registered 1-to-N write demultiplexer for the UART peripheral register path. A single write strobe with a channel select and a data word is routed to one of `NUM_CH` output slots. Each slot holds its word and raises a valid flag until the consumer acknowledges it. Overruns and out-of-range selects are detected and counted. It replaces purely combinational enable steering between the UART control logic and its register bank.

## Interface
Parameters:
- `NUM_CH`, default 4: number of output channels, range 2..16.
- `DATA_W`, default 8: data word width.
- `MODE`, default 1: 0 = PULSE (one-cycle strobe, no handshake), 1 = HOLD (valid/ack handshake).
- `CNT_W`, default 8: width of the per-block overrun counter.
- `SEL_W` is derived as `$clog2(NUM_CH)` and is not overridable.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: asynchronous active-low reset.
- `en_i` in 1: write strobe.
- `sel_i` in `SEL_W`: destination channel.
- `data_i` in `DATA_W`: write data.
- `ack_i` in `NUM_CH`: per-channel consumer acknowledge (HOLD only).
- `data_o` out `NUM_CH*DATA_W`: channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `valid_o` out `NUM_CH`: per-channel valid.
- `ovr_o` out `NUM_CH`: one-cycle overrun pulse per channel.
- `sel_err_o` out 1: one-cycle pulse when `sel_i >= NUM_CH`.
- `ovr_cnt_o` out `CNT_W`: saturating total overrun count.

## Operation
- **Reset values:** all `data_o` 0, `valid_o` 0, `ovr_o` 0, `sel_err_o` 0, `ovr_cnt_o` 0, and every slot in EMPTY.
- **Accepted write** (`en_i`=1 and `sel_i` < `NUM_CH`) targets slot `sel_i`. Other slots are unaffected.
- **Out-of-range select** (only possible when `NUM_CH` is not a power of two): the write is dropped and `sel_err_o` pulses. No slot changes.
- **HOLD mode, per-slot FSM with states EMPTY and FULL:**
  - EMPTY + write → FULL; data is loaded; `valid_o`=1.
  - FULL + `ack_i` without a write → EMPTY; `valid_o`=0; `data_o` keeps its last value.
  - FULL + write + `ack_i` in the same cycle → stays FULL; new data is loaded; no overrun.
  - FULL + write without `ack_i` → stays FULL; the old data is kept and the new data is discarded. `ovr_o[k]` pulses and `ovr_cnt_o` increments, saturating at 2^`CNT_W`−1.
  - `ack_i` while EMPTY is ignored.
- **PULSE mode:**
  - A write loads data and drives `valid_o[k]`=1 for exactly one cycle.
  - `ack_i` is ignored, `ovr_o` is never asserted, and `ovr_cnt_o` stays 0.
  - Back-to-back writes to the same channel give `valid_o` high on consecutive cycles, each with the new data.
- At most one slot is written per cycle.
- Overrun events therefore increment `ovr_cnt_o` by at most 1 per cycle.

## Timing
- **Latency:** a write sampled on edge n produces `data_o`/`valid_o` visible after edge n. That is one cycle from `en_i` to `valid_o`.
- **Ack:** `ack_i` sampled on edge n clears `valid_o` after edge n.
- **Error pulses:** `ovr_o` and `sel_err_o` are registered and are high for the single cycle following the offending edge.
- **Outputs:** all outputs are driven directly from flops, with no combinational input-to-output paths.
- **Reset mid-operation:** `rst_n_i` low asynchronously clears all state regardless of pending valids. The first write is accepted on the first rising edge with `rst_n_i` high.

## Structure
- Shared package `demux_pkg` holds:
  - `typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t`;
  - constants `MODE_PULSE`=0 and `MODE_HOLD`=1.
- Sub-module `demux_chan_slot`, instantiated `NUM_CH` times via generate:
  - inputs: `clk_i`, `rst_n_i`, `wr_i`, `data_i`, `ack_i`;
  - outputs: `data_o`, `valid_o`, `ovr_o`.
- The top level holds:
  - the select decode;
  - the range check and `sel_err_o` register;
  - the overrun counter, which ORs the slot `ovr_o` signals.

## Test plan
- **Basic write/ack:** `NUM_CH`=4, HOLD. Write 0xA5 to channel 2 → after the next edge, `data_o[2]`=0xA5 and `valid_o`=4'b0100. Then `ack_i[2]` for one cycle → `valid_o`=0 and `data_o[2]` still 0xA5.
- **Overrun:** write 0x11 then 0x22 to channel 1 with no ack → `data_o[1]`=0x11, one `ovr_o[1]` pulse, `ovr_cnt_o`=1. Repeat 300 times with `CNT_W`=8 → `ovr_cnt_o` saturates at 255.
- **Simultaneous write and ack:** channel 0 FULL with 0x33; write 0x44 with `ack_i[0]`=1 → `data_o[0]`=0x44, `valid_o[0]`=1, no `ovr_o`.
- **Range error:** `NUM_CH`=3 and `sel_i`=3 with `en_i` → `sel_err_o` pulses for one cycle; all `valid_o` and `data_o` are unchanged.
- **PULSE mode:** `MODE`=0. Writes 0x01 and 0x02 to channel 3 on consecutive cycles → `valid_o[3]` is high for two cycles carrying 0x01 then 0x02; `ack_i` has no effect; `ovr_cnt_o` stays 0.
- **Async reset:** with two channels FULL, pulse `rst_n_i` low between edges → all outputs are 0 immediately. A write on the first edge after release is accepted with one-cycle latency.
